// File: rtl/adc_snap_pkg.sv
// Shared types and bit positions for the ADC snapshot capture engine.
// Used by adc_snap_capture_ctrl (optional ADC_SNAP_OFFSET_EN build) and its bench.
package adc_snap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } state_t;

    localparam int unsigned ARM_BIT      = 0;
    localparam int unsigned TRIG_SEL_BIT = 1;
    localparam int unsigned VLD_SEL_BIT  = 2;

    localparam int unsigned DONE_BIT = 31;
    localparam int unsigned BUSY_BIT = 30;

    // Count occupies the low bits; callers pass it zero-extended.
    function automatic logic [31:0] status_word(input state_t st, input logic [31:0] cnt);
        logic [31:0] w;
        w           = cnt;
        w[DONE_BIT] = (st == DONE);
        w[BUSY_BIT] = (st == ARMED) || (st == CAPTURE);
        return w;
    endfunction

endpackage

// File: rtl/adc_snap_capture_ctrl_if.sv
// BRAM write port driven by the snapshot capture engine.
interface adc_snap_capture_ctrl_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;

    modport master (output bram_addr, bram_data, bram_we);
    modport slave  (input  bram_addr, bram_data, bram_we);
endinterface

// File: rtl/adc_snap_edge_det.sv
// Rising-edge detector on the software arm bit; one-cycle pulse output.
module adc_snap_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    output logic arm_edge
);
    logic arm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q <= 1'b0;
        end else begin
            arm_q <= arm;
        end
    end

    assign arm_edge = arm & ~arm_q;
endmodule

// File: rtl/adc_snap_capture_ctrl.sv
// Snapshot capture engine: arm + trigger writes a contiguous DEPTH-sample burst to BRAM.
// Define ADC_SNAP_OFFSET_EN to add offset_in and discard leading samples after trigger.
module adc_snap_capture_ctrl
    import adc_snap_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl_in,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              trig_in,
`ifdef ADC_SNAP_OFFSET_EN
    input  logic [31:0]       offset_in,
`endif
    adc_snap_capture_ctrl_if.master bram,
    output logic [31:0]       status_out
);
    state_t          state;
    logic [ADDR_W:0] count;
    logic            arm_edge;
    logic            trigger;
    logic            accept;
    logic            write_ok;
    logic            unused_ctrl;

    assign unused_ctrl = ^ctrl_in[31:3];

    adc_snap_edge_det u_edge_det (
        .clk      (user_clk),
        .rst_n    (user_rst_n),
        .arm      (ctrl_in[ARM_BIT]),
        .arm_edge (arm_edge)
    );

    assign trigger = ~ctrl_in[TRIG_SEL_BIT] | trig_in;
    assign accept  = ~ctrl_in[VLD_SEL_BIT] | din_valid;

`ifdef ADC_SNAP_OFFSET_EN
    logic [31:0] skip;
    assign write_ok = accept && (skip == '0);

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            skip <= '0;
        end else if (!arm_edge) begin
            if (state == ARMED && trigger) begin
                skip <= offset_in;
            end else if (state == CAPTURE && accept && skip != '0) begin
                skip <= skip - 32'd1;
            end
        end
    end
`else
    assign write_ok = accept;
`endif

    // Arm edge restarts from any state; a write registered last cycle still completes.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state          <= IDLE;
            count          <= '0;
            bram.bram_addr <= '0;
            bram.bram_data <= '0;
            bram.bram_we   <= 1'b0;
            status_out     <= '0;
        end else begin
            bram.bram_we <= 1'b0;
            status_out   <= status_word(state, 32'(count));
            if (arm_edge) begin
                state <= ARMED;
                count <= '0;
            end else begin
                case (state)
                    ARMED: begin
                        if (trigger) begin
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (write_ok) begin
                            bram.bram_we   <= 1'b1;
                            bram.bram_addr <= count[ADDR_W-1:0];
                            bram.bram_data <= din;
                            count          <= count + 1'b1;
                            if (count[ADDR_W-1:0] == '1) begin
                                state <= DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_snap_capture_ctrl.sv
// Directed bench for adc_snap_capture_ctrl with a cycle-level reference model.
module tb_adc_snap_capture_ctrl;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 4;
    localparam int          DEPTH  = 16;

    logic              user_clk   = 1'b0;
    logic              user_rst_n = 1'b0;
    logic [31:0]       ctrl_in    = '0;
    logic [DATA_W-1:0] din        = '0;
    logic              din_valid  = 1'b0;
    logic              trig_in    = 1'b0;
    logic [31:0]       status_out;
`ifdef ADC_SNAP_OFFSET_EN
    logic [31:0]       offset_in  = '0;
`endif

    adc_snap_capture_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bram_bus ();

    adc_snap_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .ctrl_in    (ctrl_in),
        .din        (din),
        .din_valid  (din_valid),
        .trig_in    (trig_in),
`ifdef ADC_SNAP_OFFSET_EN
        .offset_in  (offset_in),
`endif
        .bram       (bram_bus),
        .status_out (status_out)
    );

    always #5 user_clk = ~user_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 waiting for trigger, 2 capturing, 3 finished.
    int          m_mode, m_cnt, m_skip;
    logic        m_prev_arm;
    logic        m_we;
    logic [3:0]  m_addr;
    logic [63:0] m_data;
    logic [31:0] m_status;

    always @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            m_mode = 0; m_cnt = 0; m_skip = 0; m_prev_arm = 1'b0;
            m_we = 1'b0; m_addr = '0; m_data = '0; m_status = '0;
        end else begin
            m_status = (m_mode == 3 ? 32'h8000_0000 : 32'h0)
                     | ((m_mode == 1 || m_mode == 2) ? 32'h4000_0000 : 32'h0)
                     | 32'(m_cnt);
            m_we = 1'b0;
            if (ctrl_in[0] && !m_prev_arm) begin
                m_mode = 1;
                m_cnt  = 0;
            end else if (m_mode == 1) begin
                if (!ctrl_in[1] || trig_in) begin
                    m_mode = 2;
`ifdef ADC_SNAP_OFFSET_EN
                    m_skip = int'(offset_in);
`else
                    m_skip = 0;
`endif
                end
            end else if (m_mode == 2 && (!ctrl_in[2] || din_valid)) begin
                if (m_skip > 0) begin
                    m_skip--;
                end else begin
                    m_we   = 1'b1;
                    m_addr = 4'(m_cnt);
                    m_data = din;
                    m_cnt++;
                    if (m_cnt == DEPTH) m_mode = 3;
                end
            end
            m_prev_arm = ctrl_in[0];
        end
    end

    int          wr_cnt = 0;
    int          first_addr = -1;
    logic [63:0] mem [DEPTH];

    always @(negedge user_clk) begin
        check("bram_we",    64'(bram_bus.bram_we),   64'(m_we));
        check("bram_addr",  64'(bram_bus.bram_addr), 64'(m_addr));
        check("bram_data",  bram_bus.bram_data,      m_data);
        check("status_out", 64'(status_out),         64'(m_status));
        if (bram_bus.bram_we) begin
            if (wr_cnt == 0) first_addr = int'(bram_bus.bram_addr);
            mem[bram_bus.bram_addr] = bram_bus.bram_data;
            wr_cnt++;
        end
    end

    // Drop arm, raise it with the given mode bits; returns on the negedge after the arm edge.
    task automatic arm(input logic [31:0] bits);
        ctrl_in = bits & 32'hFFFF_FFFE;
        @(negedge user_clk);
        ctrl_in = bits | 32'h1;
        @(negedge user_clk);
        wr_cnt     = 0;
        first_addr = -1;
    endtask

    task automatic ramp(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            din = base + 64'(i);
            @(negedge user_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge user_clk);
        check("reset_status", 64'(status_out), 64'h0);
        check("reset_we",     64'(bram_bus.bram_we), 64'h0);
        check("reset_addr",   64'(bram_bus.bram_addr), 64'h0);
        user_rst_n = 1'b1;
        @(negedge user_clk);

        // Immediate capture, every cycle
        arm(32'h0);
        @(negedge user_clk);
        ramp(64'h100, 20);
        check("imm_writes", 64'(wr_cnt), 64'd16);
        check("imm_mem0",   mem[0],  64'h100);
        check("imm_mem15",  mem[15], 64'h10F);
        check("imm_status", 64'(status_out), 64'h8000_0010);
        check("imm_we_low", 64'(bram_bus.bram_we), 64'h0);

        // External trigger held low, then pulsed
        arm(32'h2);
        repeat (20) @(negedge user_clk);
        check("trig_nowrite", 64'(wr_cnt), 64'd0);
        check("trig_busy",    64'(status_out), 64'h4000_0000);
        trig_in = 1'b1;
        din     = 64'h200;
        @(negedge user_clk);
        trig_in = 1'b0;
        din     = 64'h201;
        check("trig_lat1_we", 64'(bram_bus.bram_we), 64'h0);
        @(negedge user_clk);
        check("trig_lat2_we",   64'(bram_bus.bram_we), 64'h1);
        check("trig_lat2_addr", 64'(bram_bus.bram_addr), 64'h0);
        check("trig_lat2_data", bram_bus.bram_data, 64'h201);
        ramp(64'h202, 20);
        check("trig_writes", 64'(wr_cnt), 64'd16);
        check("trig_status", 64'(status_out), 64'h8000_0010);

        // Valid gating, din_valid alternating
        arm(32'h4);
        for (int i = 0; i < 40; i++) begin
            din       = 64'h300 + 64'(i);
            din_valid = (i % 2 == 0);
            @(negedge user_clk);
        end
        din_valid = 1'b0;
        check("vld_writes", 64'(wr_cnt), 64'd16);
        check("vld_mem0",   mem[0],  64'h302);
        check("vld_mem15",  mem[15], 64'h320);
        check("vld_status", 64'(status_out), 64'h8000_0010);

        // Re-arm in the middle of a capture
        arm(32'h0);
        @(negedge user_clk);
        ramp(64'h400, 5);
        arm(32'h0);
        @(negedge user_clk);
        ramp(64'h500, 20);
        check("rearm_writes", 64'(wr_cnt), 64'd16);
        check("rearm_first",  64'(first_addr), 64'd0);
        check("rearm_mem0",   mem[0],  64'h500);
        check("rearm_mem15",  mem[15], 64'h50F);
        check("rearm_status", 64'(status_out), 64'h8000_0010);

        // Reset in the middle of a capture
        arm(32'h0);
        @(negedge user_clk);
        ramp(64'h600, 7);
        #1;
        check("rst_pre_writes", 64'(wr_cnt), 64'd7);
        @(posedge user_clk);
        #2;
        user_rst_n = 1'b0;
        ctrl_in    = '0;
        #1;
        check("rst_status", 64'(status_out), 64'h0);
        check("rst_we",     64'(bram_bus.bram_we), 64'h0);
        check("rst_addr",   64'(bram_bus.bram_addr), 64'h0);
        check("rst_data",   bram_bus.bram_data, 64'h0);
        repeat (3) @(negedge user_clk);
        user_rst_n = 1'b1;
        wr_cnt     = 0;
        ramp(64'h700, 10);
        check("rst_idle_writes", 64'(wr_cnt), 64'd0);
        check("rst_idle_status", 64'(status_out), 64'h0);

`ifdef ADC_SNAP_OFFSET_EN
        offset_in = 32'd3;
        arm(32'h0);
        @(negedge user_clk);
        ramp(64'h0, 25);
        check("ofs3_writes", 64'(wr_cnt), 64'd16);
        check("ofs3_mem0",   mem[0],  64'd3);
        check("ofs3_mem15",  mem[15], 64'd18);
        offset_in = 32'd0;
        arm(32'h0);
        @(negedge user_clk);
        ramp(64'h100, 20);
        check("ofs0_writes", 64'(wr_cnt), 64'd16);
        check("ofs0_mem0",   mem[0],  64'h100);
        check("ofs0_mem15",  mem[15], 64'h10F);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
